// File: rtl/branch_resolver_if.sv
// Bundles the fetch-side prediction push, the EX resolution inputs and the
// resolution/flush outputs of the branch resolver.
interface branch_resolver_if;
  logic        Pred_push;
  logic [31:0] Pred_PC;
  logic        Pred_taken;
  logic [31:0] Pred_addr;
  logic [1:0]  Pred_bits;
  logic        Ex_valid;
  logic [31:0] Ex_PC;
  logic [31:0] Ex_instr;
  logic        Ex_taken;
  logic [31:0] Ex_target;
  logic [31:0] Branch_instr;
  logic [31:0] Branch_addr;
  logic        Branch_resolved;
  logic [31:0] Branch_resolved_addr;
  logic [1:0]  Branch_predictions;
  logic        Flush;
  logic [31:0] Redirect_addr;
  logic        Overflow;
  logic        Seq_error;
  logic [31:0] Branch_count;
  logic [31:0] Mispredict_count;

  modport master (
    output Pred_push, Pred_PC, Pred_taken, Pred_addr, Pred_bits,
           Ex_valid, Ex_PC, Ex_instr, Ex_taken, Ex_target,
    input  Branch_instr, Branch_addr, Branch_resolved, Branch_resolved_addr,
           Branch_predictions, Flush, Redirect_addr, Overflow, Seq_error,
           Branch_count, Mispredict_count
  );

  modport slave (
    input  Pred_push, Pred_PC, Pred_taken, Pred_addr, Pred_bits,
           Ex_valid, Ex_PC, Ex_instr, Ex_taken, Ex_target,
    output Branch_instr, Branch_addr, Branch_resolved, Branch_resolved_addr,
           Branch_predictions, Flush, Redirect_addr, Overflow, Seq_error,
           Branch_count, Mispredict_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves queued fetch predictions against EX outcomes; record/flush registered, 1-cycle latency.
// No backpressure: pushes on a full queue are dropped (sticky Overflow), EX traffic is ignored while draining.
module branch_resolver #(
  parameter int          DEPTH           = 4,
  parameter int          DRAIN_CYCLES    = 2,
  parameter logic [31:0] FALLTHRU_OFFSET = 32'd8
) (
  input logic              CLK,
  input logic              RESET,
  branch_resolver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] addr;
    logic [1:0]  bits;
  } pred_t;

  typedef enum logic {RUN, DRAIN} state_t;

  pred_t          pred_q [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  state_t         state;
  logic [DW-1:0]  drain_cnt;

  logic        empty, full, accept, pop, push, mispredict, overflow_evt;
  pred_t       head;
  logic [31:0] redirect;

  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    accept       = bus.Ex_valid && (state == RUN);
    pop          = accept && !empty;
    // An empty queue resolves against a not-taken, zero-target default.
    head         = empty ? '0 : pred_q[rd_ptr[AW-1:0]];
    mispredict   = accept && ((head.taken != bus.Ex_taken) ||
                              (bus.Ex_taken && (head.addr != bus.Ex_target)));
    push         = bus.Pred_push && (state == RUN) && !mispredict && (!full || pop);
    overflow_evt = bus.Pred_push && (state == RUN) && full && !pop;
    redirect     = bus.Ex_taken ? bus.Ex_target : bus.Ex_PC + FALLTHRU_OFFSET;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pred_q[wr_ptr[AW-1:0]] <= '{pc: bus.Pred_PC, taken: bus.Pred_taken,
                                  addr: bus.Pred_addr, bits: bus.Pred_bits};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state                    <= RUN;
      drain_cnt                <= '0;
      wr_ptr                   <= '0;
      rd_ptr                   <= '0;
      bus.Branch_instr         <= '0;
      bus.Branch_addr          <= '0;
      bus.Branch_resolved      <= 1'b0;
      bus.Branch_resolved_addr <= '0;
      bus.Branch_predictions   <= '0;
      bus.Flush                <= 1'b0;
      bus.Redirect_addr        <= '0;
      bus.Overflow             <= 1'b0;
      bus.Seq_error            <= 1'b0;
      bus.Branch_count         <= '0;
      bus.Mispredict_count     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mispredict && (DRAIN_CYCLES != 0)) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (drain_cnt <= 1) state <= RUN;
          else                drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase

      // A mispredict discards everything fetched down the wrong path.
      if (mispredict) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
      end

      bus.Branch_instr         <= accept ? bus.Ex_instr  : '0;
      bus.Branch_addr          <= accept ? bus.Ex_PC     : '0;
      bus.Branch_resolved      <= accept && bus.Ex_taken;
      bus.Branch_resolved_addr <= accept ? bus.Ex_target : '0;
      bus.Branch_predictions   <= accept ? head.bits     : '0;
      bus.Flush                <= mispredict;
      bus.Redirect_addr        <= mispredict ? redirect  : '0;

      if (overflow_evt)                 bus.Overflow  <= 1'b1;
      if (pop && head.pc != bus.Ex_PC)  bus.Seq_error <= 1'b1;
      if (accept)     bus.Branch_count     <= bus.Branch_count + 32'd1;
      if (mispredict) bus.Mispredict_count <= bus.Mispredict_count + 32'd1;
    end
  end
endmodule
